// File: rtl/five_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory port, CU decision inputs and the
// fetch-side status/decode outputs. The fetch unit is the master; the
// surrounding CPU (memory, CU, datapath) connects through the slave side.
interface five_fetch_unit_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16
);
    logic                imem_en;
    logic [ADDR_W-1:0]   imem_addr;
    logic [INSTR_W-1:0]  imem_rdata;

    logic                cu_stop;
    logic                cu_wr_pc;
    logic                cu_wr_none_pc;
    logic                acc_neg;
    logic                resume;

    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   addr_field;
    logic [ADDR_W-1:0]   pc;
    logic                exec_en;
    logic                halted;
    logic [CNT_W-1:0]    instr_cnt;

    modport master (
        output imem_en,
        output imem_addr,
        input  imem_rdata,
        input  cu_stop,
        input  cu_wr_pc,
        input  cu_wr_none_pc,
        input  acc_neg,
        input  resume,
        output opcode,
        output addr_field,
        output pc,
        output exec_en,
        output halted,
        output instr_cnt
    );

    modport slave (
        input  imem_en,
        input  imem_addr,
        output imem_rdata,
        output cu_stop,
        output cu_wr_pc,
        output cu_wr_none_pc,
        output acc_neg,
        output resume,
        input  opcode,
        input  addr_field,
        input  pc,
        input  exec_en,
        input  halted,
        input  instr_cnt
    );
endinterface

// File: rtl/five_fetch_unit.sv
// Instruction fetch / sequencing stage of the accumulator CPU.
// Owns PC and IR, reads instruction memory, hands opcode/address to the CU
// and resolves the CU's stop / branch / jump decisions into the next PC.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   FETCH   | imem read issued at pc
//   DECODE  | instruction word captured into ir
//   EXEC    | exec_en strobe; CU decisions sampled, next pc resolved
//   HALT    | stopped; pc/ir hold until resume (continues at pc+1)
module five_fetch_unit #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    five_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [INSTR_W-1:0]  ir_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_field;

    logic                ir_load;
    logic                cnt_inc;
    logic                imem_en_c;
    logic                exec_en_c;
    logic                halted_c;

    assign addr_field = ir_q[ADDR_W-1:0];

    // Sequential state: FSM, program counter, instruction register, retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (ir_load) begin
                ir_q <= bus.imem_rdata;
            end
            if (cnt_inc && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    // Next-state / next-pc decode; strobes depend on state only so the CU
    // inputs never reach an output combinationally.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_load   = 1'b0;
        cnt_inc   = 1'b0;
        imem_en_c = 1'b0;
        exec_en_c = 1'b0;
        halted_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_en_c = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ir_load = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                exec_en_c = 1'b1;
                cnt_inc   = 1'b1;
                // Stop wins over any concurrent jump/branch request.
                if (bus.cu_stop) begin
                    state_d = S_HALT;
                end else if (bus.cu_wr_none_pc) begin
                    pc_d    = addr_field;
                    state_d = S_FETCH;
                end else if (bus.cu_wr_pc && bus.acc_neg) begin
                    pc_d    = addr_field;
                    state_d = S_FETCH;
                end else begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                halted_c = 1'b1;
                if (bus.resume) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // IR bits between the address field and the opcode carry no meaning here.
    generate
        if (ADDR_W < INSTR_W - 4) begin : g_ir_gap
            logic unused_ir_gap;
            assign unused_ir_gap = ^ir_q[INSTR_W-5:ADDR_W];
        end
    endgenerate

    assign bus.imem_en    = imem_en_c;
    assign bus.imem_addr  = pc_q;
    assign bus.opcode     = ir_q[INSTR_W-1 -: 4];
    assign bus.addr_field = addr_field;
    assign bus.pc         = pc_q;
    assign bus.exec_en    = exec_en_c;
    assign bus.halted     = halted_c;
    assign bus.instr_cnt  = cnt_q;

endmodule

// File: tb/tb_five_fetch_unit.sv
// Bench for five_fetch_unit: per-instruction stepping with a scoreboard of
// expected EXEC strobes, a vector table for next-pc decisions, and hand
// sequences for halt/resume, counter saturation and reset during EXEC.
module tb_five_fetch_unit;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    five_fetch_unit_if #(.INSTR_W(16), .ADDR_W(8), .CNT_W(CW)) bus ();

    five_fetch_unit #(.INSTR_W(16), .ADDR_W(8), .CNT_W(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [256];

    // Synchronous instruction memory: data one cycle after imem_en.
    always @(posedge clk) begin
        if (bus.imem_en === 1'b1) bus.imem_rdata <= mem[bus.imem_addr];
    end

    // Cycle 1 is the cycle right after the last reset edge (FETCH).
    int cyc = 0;
    always @(posedge clk) cyc <= rst ? 1 : cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [7:0]    m_pc;
    logic [CW-1:0] m_cnt;

    typedef struct {
        int         cyc;
        logic [7:0] pc;
        logic [3:0] op;
        logic [7:0] addr;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [7:0]  pc0;
        logic [15:0] instr;
        logic        s;
        logic        wp;
        logic        wn;
        logic        neg;
        logic [7:0]  exp_pc;
        logic        exp_halt;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every exec_en strobe must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (bus.exec_en === 1'b1) begin : pop
            sb_t e;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_exec actual=exec_en required=no_exec pc=0x%0h", bus.pc);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc", bus.pc, e.pc);
                check("sb_opcode", bus.opcode, e.op);
                check("sb_addr_field", bus.addr_field, e.addr);
                if (e.cyc != 0) check("sb_exec_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic cu_clear();
        bus.cu_stop       = 1'b0;
        bus.cu_wr_pc      = 1'b0;
        bus.cu_wr_none_pc = 1'b0;
        bus.acc_neg       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cu_clear();
        bus.resume = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_pc  = 8'h00;
        m_cnt = '0;
    endtask

    // Runs one instruction from FETCH; CU decisions are presented from DECODE
    // on so they are stable when EXEC ends.
    task automatic do_instr(input logic [15:0] instr, input logic s, input logic wp,
                            input logic wn, input logic neg, input logic [7:0] exp_pc,
                            input logic exp_halt, input int exp_cyc);
        sb_t e;
        mem[m_pc] = instr;
        e.cyc  = exp_cyc;
        e.pc   = m_pc;
        e.op   = instr[15:12];
        e.addr = instr[7:0];
        sb_q.push_back(e);
        check("fetch_en", bus.imem_en, 1);
        check("fetch_addr", bus.imem_addr, m_pc);
        @(posedge clk); @(negedge clk);
        check("decode_no_imem", bus.imem_en, 0);
        bus.cu_stop       = s;
        bus.cu_wr_pc      = wp;
        bus.cu_wr_none_pc = wn;
        bus.acc_neg       = neg;
        @(posedge clk); @(negedge clk);
        check("exec_strobe", bus.exec_en, 1);
        @(posedge clk); @(negedge clk);
        cu_clear();
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        m_pc = exp_pc;
        check("next_pc", bus.pc, exp_pc);
        check("halted", bus.halted, exp_halt);
        check("exec_cleared", bus.exec_en, 0);
        check("instr_cnt", bus.instr_cnt, m_cnt);
        if (!exp_halt) check("next_fetch_addr", bus.imem_addr, exp_pc);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        //            pc0    instr     s     wp    wn    neg   exp_pc halt
        vecs[0] = '{8'h00, 16'h8040, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 1'b0};
        vecs[1] = '{8'h04, 16'h9010, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0};
        vecs[2] = '{8'h04, 16'h9010, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 1'b0};
        vecs[3] = '{8'h20, 16'hF0AA, 1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 1'b1};
        vecs[4] = '{8'hFF, 16'h1005, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h30, 16'h2006, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31, 1'b0};
        vecs[6] = '{8'h07, 16'h8033, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0};
        vecs[7] = '{8'h50, 16'h9012, 1'b1, 1'b1, 1'b0, 1'b1, 8'h50, 1'b1};

        // Reset state.
        do_reset();
        check("rst_pc", bus.pc, 0);
        check("rst_exec_en", bus.exec_en, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_instr_cnt", bus.instr_cnt, 0);
        check("rst_imem_en", bus.imem_en, 1);
        check("rst_opcode", bus.opcode, 0);
        check("rst_addr_field", bus.addr_field, 0);

        // LDA 5, ADD 6, STOP: strobes at cycles 3, 6, 9; halted from 10.
        do_instr(16'h1005, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 3);
        do_instr(16'h2006, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 6);
        do_instr(16'hF000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 1'b1, 9);
        check("prog_instr_cnt", bus.instr_cnt, 3);
        @(posedge clk); @(negedge clk);
        check("prog_still_halted", bus.halted, 1);
        check("prog_halt_pc", bus.pc, 8'h02);

        // Next-pc decision table.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (vecs[i].pc0 != 8'h00)
                do_instr(16'h8000 | {8'h00, vecs[i].pc0}, 1'b0, 1'b0, 1'b1, 1'b0,
                         vecs[i].pc0, 1'b0, 0);
            do_instr(vecs[i].instr, vecs[i].s, vecs[i].wp, vecs[i].wn, vecs[i].neg,
                     vecs[i].exp_pc, vecs[i].exp_halt, 0);
        end

        // Halt with concurrent jump, hold, resume, then resume outside HALT.
        do_reset();
        do_instr(16'hF044, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("halt_hold", bus.halted, 1);
            check("halt_pc_hold", bus.pc, 8'h00);
            check("halt_no_imem", bus.imem_en, 0);
            check("halt_no_exec", bus.exec_en, 0);
        end
        bus.resume = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.resume = 1'b0;
        m_pc = 8'h01;
        check("resume_halted", bus.halted, 0);
        check("resume_pc", bus.pc, 8'h01);
        check("resume_fetch_en", bus.imem_en, 1);
        check("resume_fetch_addr", bus.imem_addr, 8'h01);
        bus.resume = 1'b1;
        do_instr(16'h1003, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 0);
        bus.resume = 1'b0;

        // Retire counter saturation (4-bit counter).
        do_reset();
        for (int i = 0; i < 17; i++)
            do_instr(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, m_pc + 8'd1, 1'b0, 0);
        check("cnt_saturated", bus.instr_cnt, 4'hF);

        // Reset during EXEC of a jump: instruction discarded.
        do_reset();
        mem[0] = 16'h8040;
        sb_q.push_back('{0, 8'h00, 4'h8, 8'h40});
        @(posedge clk); @(negedge clk);
        bus.cu_wr_none_pc = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rstexec_strobe", bus.exec_en, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        cu_clear();
        check("rstexec_pc", bus.pc, 0);
        check("rstexec_exec_en", bus.exec_en, 0);
        check("rstexec_instr_cnt", bus.instr_cnt, 0);
        check("rstexec_fetch", bus.imem_en, 1);
        check("rstexec_halted", bus.halted, 0);
        @(posedge clk); @(negedge clk);
        check("rstexec_decode_no_exec", bus.exec_en, 0);
        check("rstexec_decode_pc", bus.pc, 0);

        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
